// File: rtl/baseline_tracker.sv
`default_nettype none
// ============================================================================
// Module      : baseline_tracker
// Description : Calibration averager and IIR baseline accumulator for the
//               capacitive touch filter.
//               - cal_en    : sum 2^CAL_LOG2 samples, then load the average as
//                             the baseline and pulse cal_done.
//               - track_en  : acc <= acc + sample - (acc >> BASE_SHIFT).
//               - otherwise : accumulator frozen.
// Ports       : clk, reset (sync, active-high), sample_valid, sample[7:0],
//               cal_en, track_en, cal_done (combinational, high on the
//               strobe that completes calibration), baseline[7:0].
// Revision    : 1.0 - initial release
// ============================================================================
module baseline_tracker #(
  parameter int BASE_SHIFT = 4,
  parameter int CAL_LOG2   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic       cal_en,
  input  logic       track_en,
  output logic       cal_done,
  output logic [7:0] baseline
);

  localparam int ACC_W = 8 + BASE_SHIFT;
  localparam int SUM_W = 8 + CAL_LOG2;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam int CAL_N = 1 << CAL_LOG2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cal_cnt_q, cal_cnt_d;

  logic [SUM_W-1:0] sum_next;
  logic [7:0]       cal_avg;
  logic [ACC_W-1:0] acc_next;
  logic             cal_last;

  assign sum_next = sum_q + SUM_W'(sample);
  assign cal_avg  = sum_next[SUM_W-1:CAL_LOG2];
  assign cal_last = (cal_cnt_q == CNT_W'(CAL_N - 1));

  // acc - (acc >> BASE_SHIFT) never underflows and the final result never
  // exceeds 255 << BASE_SHIFT, so modular ACC_W-bit arithmetic is exact.
  assign acc_next = acc_q - (acc_q >> BASE_SHIFT) + ACC_W'(sample);

  assign baseline = acc_q[ACC_W-1:BASE_SHIFT];

  always_comb begin
    acc_d     = acc_q;
    sum_d     = sum_q;
    cal_cnt_d = cal_cnt_q;
    cal_done  = 1'b0;
    if (sample_valid && cal_en) begin
      if (cal_last) begin
        cal_done  = 1'b1;
        acc_d     = {cal_avg, {BASE_SHIFT{1'b0}}};
        // Leave the sum clean so a later recalibration starts from zero.
        sum_d     = '0;
        cal_cnt_d = '0;
      end else begin
        sum_d     = sum_next;
        cal_cnt_d = cal_cnt_q + CNT_W'(1);
      end
    end else if (sample_valid && track_en) begin
      acc_d = acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      sum_q     <= '0;
      cal_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      cal_cnt_q <= cal_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/touch_filter.sv
`default_nettype none
// ============================================================================
// Module      : touch_filter
// Description : Debounced capacitive touch detector with calibrated,
//               slowly tracking baseline and touch-duration timeout that
//               forces a recalibration.
// Ports       : clk           - single clock, posedge
//               reset         - synchronous, active-high
//               sample_valid  - strobe for a new raw count
//               sample[7:0]   - raw charge-time count
//               ready         - calibration complete
//               touched       - debounced touch state
//               press         - pulse on touched 0->1
//               release_pulse - pulse on touched 1->0 (named so because
//                               'release' is a reserved word)
//               delta[7:0]    - sample minus baseline, floored at 0
//               baseline[7:0] - current baseline
// Revision    : 1.0 - initial release
// ============================================================================
module touch_filter #(
  parameter int ON_DELTA   = 12,
  parameter int OFF_DELTA  = 6,
  parameter int DEBOUNCE   = 3,
  parameter int BASE_SHIFT = 4,
  parameter int CAL_LOG2   = 3,
  parameter int MAX_TOUCH  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic       ready,
  output logic       touched,
  output logic       press,
  output logic       release_pulse,
  output logic [7:0] delta,
  output logic [7:0] baseline
);

  localparam logic [2:0] S_CALIB     = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_PRESSING  = 3'd2;
  localparam logic [2:0] S_TOUCHED   = 3'd3;
  localparam logic [2:0] S_RELEASING = 3'd4;

  localparam logic [7:0] ON_TH  = 8'(ON_DELTA);
  localparam logic [7:0] OFF_TH = 8'(OFF_DELTA);
  localparam logic [3:0] DEB_TH = 4'(DEBOUNCE);
  localparam logic [7:0] MAX_TH = 8'(MAX_TOUCH);

  logic [2:0] state_q, state_d;
  logic [3:0] deb_q, deb_d;
  logic [7:0] dur_q, dur_d;
  logic       ready_q, ready_d;
  logic       touched_q, touched_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic [7:0] delta_q, delta_d;

  logic       cal_done;
  logic [7:0] base_now;
  logic [7:0] delta_now;
  logic       on_hit;
  logic       off_hit;
  logic [3:0] deb_inc;
  logic [7:0] dur_inc;

  baseline_tracker #(
    .BASE_SHIFT (BASE_SHIFT),
    .CAL_LOG2   (CAL_LOG2)
  ) u_baseline (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .cal_en       (state_q == S_CALIB),
    .track_en     (state_q == S_IDLE),
    .cal_done     (cal_done),
    .baseline     (base_now)
  );

  // base_now is the pre-update baseline, so delta sees the baseline as it
  // stood before this sample was folded in.
  assign delta_now = (sample > base_now) ? (sample - base_now) : 8'd0;
  assign on_hit    = (delta_now >= ON_TH);
  assign off_hit   = (delta_now <  OFF_TH);
  assign deb_inc   = deb_q + 4'd1;
  assign dur_inc   = dur_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    dur_d     = dur_q;
    ready_d   = ready_q;
    touched_d = touched_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    delta_d   = delta_q;
    if (sample_valid) begin
      delta_d = (state_q == S_CALIB) ? 8'd0 : delta_now;
      case (state_q)
        S_CALIB: begin
          if (cal_done) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end
        end
        S_IDLE: begin
          if (on_hit) begin
            if (DEB_TH == 4'd1) begin
              state_d   = S_TOUCHED;
              touched_d = 1'b1;
              press_d   = 1'b1;
              dur_d     = 8'd0;
              deb_d     = 4'd0;
            end else begin
              state_d = S_PRESSING;
              deb_d   = 4'd1;
            end
          end
        end
        S_PRESSING: begin
          if (on_hit) begin
            if (deb_inc == DEB_TH) begin
              state_d   = S_TOUCHED;
              touched_d = 1'b1;
              press_d   = 1'b1;
              dur_d     = 8'd0;
              deb_d     = 4'd0;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            state_d = S_IDLE;
            deb_d   = 4'd0;
          end
        end
        S_TOUCHED, S_RELEASING: begin
          // Duration keeps running through RELEASING so a flickering hold
          // still times out; the timeout outranks the debounce transitions.
          dur_d = dur_inc;
          if (dur_inc == MAX_TH) begin
            state_d   = S_CALIB;
            touched_d = 1'b0;
            ready_d   = 1'b0;
            release_d = 1'b1;
            deb_d     = 4'd0;
            dur_d     = 8'd0;
          end else if (state_q == S_TOUCHED) begin
            if (off_hit) begin
              if (DEB_TH == 4'd1) begin
                state_d   = S_IDLE;
                touched_d = 1'b0;
                release_d = 1'b1;
                deb_d     = 4'd0;
              end else begin
                state_d = S_RELEASING;
                deb_d   = 4'd1;
              end
            end
          end else begin
            if (off_hit) begin
              if (deb_inc == DEB_TH) begin
                state_d   = S_IDLE;
                touched_d = 1'b0;
                release_d = 1'b1;
                deb_d     = 4'd0;
              end else begin
                deb_d = deb_inc;
              end
            end else begin
              state_d = S_TOUCHED;
              deb_d   = 4'd0;
            end
          end
        end
        default: begin
          state_d = S_CALIB;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CALIB;
      deb_q     <= 4'd0;
      dur_q     <= 8'd0;
      ready_q   <= 1'b0;
      touched_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      delta_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      dur_q     <= dur_d;
      ready_q   <= ready_d;
      touched_q <= touched_d;
      press_q   <= press_d;
      release_q <= release_d;
      delta_q   <= delta_d;
    end
  end

  assign ready         = ready_q;
  assign touched       = touched_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign delta         = delta_q;
  assign baseline      = base_now;

endmodule
`default_nettype wire

// File: tb/tb_touch_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_touch_filter
// Description : Self-checking bench for touch_filter. A behavioural model
//               (sample-list calibration, integer IIR, run-length debounce)
//               predicts every output each cycle; directed scenarios pin
//               known values, then randomized segments follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_touch_filter;

  localparam int ON    = 12;
  localparam int OFF   = 6;
  localparam int DEB   = 3;
  localparam int BS    = 4;
  localparam int CL    = 3;
  localparam int MAXT  = 255;

  logic       clk;
  logic       reset;
  logic       sample_valid;
  logic [7:0] sample;
  logic       ready;
  logic       touched;
  logic       press;
  logic       release_pulse;
  logic [7:0] delta;
  logic [7:0] baseline;

  touch_filter #(
    .ON_DELTA   (ON),
    .OFF_DELTA  (OFF),
    .DEBOUNCE   (DEB),
    .BASE_SHIFT (BS),
    .CAL_LOG2   (CL),
    .MAX_TOUCH  (MAXT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .sample        (sample),
    .ready         (ready),
    .touched       (touched),
    .press         (press),
    .release_pulse (release_pulse),
    .delta         (delta),
    .baseline      (baseline)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit m_calib;
  int m_cal_list[$];
  int m_acc;
  bit m_ready;
  bit m_touched;
  int m_run;   // consecutive samples qualifying toward a state change
  int m_dur;   // samples since the touch began
  int exp_delta;
  bit exp_press;
  bit exp_release;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int s);
    int b;
    int d;
    int sum;
    exp_press   = 0;
    exp_release = 0;
    if (r) begin
      m_calib = 1; m_cal_list.delete(); m_acc = 0; m_ready = 0;
      m_touched = 0; m_run = 0; m_dur = 0; exp_delta = 0;
      return;
    end
    if (!v) return;
    b = m_acc >> BS;
    if (m_calib) begin
      exp_delta = 0;
      m_cal_list.push_back(s);
      if (m_cal_list.size() == (1 << CL)) begin
        sum = 0;
        foreach (m_cal_list[i]) sum += m_cal_list[i];
        m_acc = (sum / (1 << CL)) * (1 << BS);
        m_cal_list.delete();
        m_calib = 0;
        m_ready = 1;
        m_run   = 0;
      end
      return;
    end
    d = (s > b) ? s - b : 0;
    exp_delta = d;
    if (!m_touched) begin
      // Baseline only tracks while nothing is building toward a touch.
      if (m_run == 0) m_acc = m_acc + s - (m_acc / (1 << BS));
      if (d >= ON) begin
        m_run++;
        if (m_run == DEB) begin
          m_touched = 1; exp_press = 1; m_dur = 0; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      m_dur++;
      if (m_dur == MAXT) begin
        m_touched = 0; exp_release = 1; m_ready = 0; m_calib = 1; m_run = 0;
      end else if (d < OFF) begin
        m_run++;
        if (m_run == DEB) begin
          m_touched = 0; exp_release = 1; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("ready",    int'(ready),         int'(m_ready));
    chk("touched",  int'(touched),       int'(m_touched));
    chk("press",    int'(press),         int'(exp_press));
    chk("release",  int'(release_pulse), int'(exp_release));
    chk("delta",    int'(delta),         exp_delta);
    chk("baseline", int'(baseline),      m_acc >> BS);
  endtask

  // One clock: drive inputs, predict, let the edge pass, compare at negedge.
  task automatic cycle(input bit r, input bit v, input int s);
    reset        = r;
    sample_valid = v;
    sample       = 8'(s);
    model_step(r, v, s);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    cycle(1, 0, 0);
    cycle(1, 1, 77);
  endtask

  task automatic calib(input int val);
    for (int i = 0; i < (1 << CL); i++) cycle(0, 1, val);
  endtask

  int prev_base;
  int press_seen;

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample = 8'd0;

    // Reset state
    do_reset();
    chk("rst_ready", int'(ready), 0);
    chk("rst_baseline", int'(baseline), 0);
    chk("rst_delta", int'(delta), 0);

    // Calibration at 100 with an idle gap in the middle
    for (int i = 0; i < 4; i++) cycle(0, 1, 100);
    cycle(0, 0, 200);
    for (int i = 0; i < 4; i++) cycle(0, 1, 100);
    chk("cal_ready", int'(ready), 1);
    chk("cal_baseline", int'(baseline), 100);
    chk("cal_touched", int'(touched), 0);

    // Press after three strong samples
    for (int i = 0; i < 3; i++) cycle(0, 1, 115);
    chk("press_pulse", int'(press), 1);
    chk("press_touched", int'(touched), 1);
    chk("press_delta", int'(delta), 15);
    chk("press_baseline", int'(baseline), 100);
    cycle(0, 0, 0);
    chk("press_one_cycle", int'(press), 0);

    // Hysteresis hold then debounced release
    cycle(0, 1, 110);
    chk("hold_touched", int'(touched), 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 104);
    chk("rel_pulse", int'(release_pulse), 1);
    chk("rel_touched", int'(touched), 0);

    // Interrupted press does not register
    cycle(0, 1, 115); cycle(0, 1, 100); cycle(0, 1, 115); cycle(0, 1, 115);
    chk("bounce_touched", int'(touched), 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 100);

    // Baseline falls toward 90, never rising
    do_reset(); calib(100);
    prev_base = 100; press_seen = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(0, 1, 90);
      chk("fall_nonincr", int'(baseline) <= prev_base ? 1 : 0, 1);
      prev_base = int'(baseline);
      press_seen += int'(press);
    end
    chk("fall_reached", int'(baseline), 90);
    chk("fall_nopress", press_seen, 0);

    // Long touch times out and recalibrates
    do_reset(); calib(100);
    for (int i = 0; i < 300; i++) begin
      cycle(0, 1, 130);
      if (i == 2)   chk("long_press", int'(press), 1);
      if (i == 257) begin
        chk("timeout_release", int'(release_pulse), 1);
        chk("timeout_ready", int'(ready), 0);
        chk("timeout_touched", int'(touched), 0);
      end
      if (i == 265) begin
        chk("recal_baseline", int'(baseline), 130);
        chk("recal_ready", int'(ready), 1);
      end
    end

    // Reset while touched: everything clears without a release pulse
    do_reset(); calib(100);
    for (int i = 0; i < 20; i++) cycle(0, 1, 130);
    chk("pre_reset_touched", int'(touched), 1);
    cycle(1, 1, 130);
    chk("mid_reset_release", int'(release_pulse), 0);
    chk("mid_reset_touched", int'(touched), 0);
    chk("mid_reset_baseline", int'(baseline), 0);

    // Randomized segments steered around the model's baseline
    cycle(0, 0, 0);
    for (int seg = 0; seg < 400; seg++) begin
      int mode;
      int len;
      mode = int'($urandom_range(0, 4));
      len  = int'($urandom_range(1, 20));
      for (int k = 0; k < len; k++) begin
        int base;
        int x;
        bit v;
        base = m_acc >> BS;
        case (mode)
          0:       x = base + int'($urandom_range(12, 60));
          1:       x = base - 10 + int'($urandom_range(0, 15));
          2:       x = base + int'($urandom_range(4, 14));
          3:       x = int'($urandom_range(0, 255));
          default: x = base + int'($urandom_range(0, 20));
        endcase
        if (x < 0)   x = 0;
        if (x > 255) x = 255;
        v = ($urandom_range(0, 3) != 0);
        cycle(($urandom_range(0, 499) == 0), v, x);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/touch_filter.md
TOUCH_FILTER -- requirements
Module: touch_filter

Interface
REQ-001 Parameter ON_DELTA, default 12: delta at or above which a sample counts as "touch".
REQ-002 Parameter OFF_DELTA, default 6: delta below which a sample counts as "release"; SHALL be less than or equal to ON_DELTA.
REQ-003 Parameter DEBOUNCE, default 3, range 1-15: consecutive qualifying samples required to change the touched state.
REQ-004 Parameter BASE_SHIFT, default 4, range 1-7: IIR baseline time constant, 2^BASE_SHIFT samples.
REQ-005 Parameter CAL_LOG2, default 3, range 0-6: calibration averages 2^CAL_LOG2 samples.
REQ-006 Parameter MAX_TOUCH, default 255, range 1-255: samples in TOUCHED before forced recalibration.
REQ-007 clk  in  1  single clock; all logic on posedge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 sample_valid  in  1  one-cycle strobe marking a new raw capsense count.
REQ-010 sample  in  8  raw charge-time count, unsigned; larger means more capacitance.
REQ-011 ready  out  1  high once calibration completes.
REQ-012 touched  out  1  debounced touch state.
REQ-013 press  out  1  one-cycle pulse on the 0->1 transition of touched.
REQ-014 release  out  1  one-cycle pulse on the 1->0 transition of touched, including timeout.
REQ-015 delta  out  8  sample minus baseline, clamped to 0 when sample <= baseline.
REQ-016 baseline  out  8  current baseline, integer part of the accumulator.

Function
REQ-017 States SHALL be CALIB, IDLE, PRESSING, TOUCHED and RELEASING; state changes SHALL occur only on cycles where sample_valid is high.
REQ-018 Outputs SHALL be registered; a sample strobed on cycle N SHALL be reflected in delta, touched, press and release on cycle N+1.
REQ-019 delta SHALL be computed against the baseline as it stood before that sample's baseline update.
REQ-020 CALIB: sum 2^CAL_LOG2 samples in a (8+CAL_LOG2)-bit register; on the last sample, set baseline = sum >> CAL_LOG2, set accumulator = baseline << BASE_SHIFT, raise ready, go to IDLE; delta SHALL be 0 in CALIB.
REQ-021 The accumulator SHALL be (8+BASE_SHIFT) bits wide; in IDLE only, it SHALL update as acc <= acc + sample - (acc >> BASE_SHIFT), computed without overflow; it SHALL be frozen in all other states.
REQ-022 IDLE: if delta >= ON_DELTA, clear the debounce counter to 1; if DEBOUNCE == 1, go to TOUCHED, otherwise go to PRESSING.
REQ-023 PRESSING: if delta >= ON_DELTA, increment the counter; on reaching DEBOUNCE, go to TOUCHED with press pulse; if delta < ON_DELTA, go to IDLE and clear the counter.
REQ-024 TOUCHED: if delta < OFF_DELTA, go to RELEASING with counter 1, or straight to IDLE with release if DEBOUNCE == 1; a touch-duration counter SHALL increment per sample.
REQ-025 RELEASING: if delta < OFF_DELTA, increment the counter; on reaching DEBOUNCE, go to IDLE with release pulse; if delta >= OFF_DELTA, return to TOUCHED without clearing the duration counter.
REQ-026 The touch-duration counter SHALL be cleared on entry to TOUCHED from PRESSING or IDLE.
REQ-027 When the duration counter reaches MAX_TOUCH, the block SHALL assert release, clear touched and ready, and go to CALIB; this takes priority over the REQ-024/025 transitions.
REQ-028 press and release SHALL never both be high; each SHALL be low on every cycle it is not pulsed.
REQ-029 touched SHALL be high exactly in TOUCHED and RELEASING.

Reset
REQ-030 On reset: state CALIB; ready, touched, press, release, delta and baseline = 0; accumulator, sum and all counters = 0.
REQ-031 reset SHALL take priority over sample_valid in the same cycle; reset while touched SHALL NOT emit release.

Structure
REQ-032 State encodings SHALL be local constants; there SHALL be no shared package, and parameters SHALL be the only configuration.
REQ-033 The baseline accumulator and calibration averaging SHALL form one sub-module, baseline_tracker; the debounce FSM SHALL stay in touch_filter.

Verification
REQ-034 Reset, then 8 samples of 100 -> ready=1 and baseline=100 one cycle after the 8th; touched=0.
REQ-035 After calibration at 100, samples 115,115,115 -> delta=15, press pulse and touched=1 one cycle after the 3rd; baseline stays 100.
REQ-036 After calibration at 100, samples 115,100,115,115 -> no press, touched=0.
REQ-037 In TOUCHED, samples 110,104,104,104 -> touched stays 1 after 110; release pulse and touched=0 one cycle after the final 104.
REQ-038 After calibration at 100, sample 90 repeated -> baseline non-increasing, reaching 90 within 64 samples, no press.
REQ-039 After calibration at 100, 300 samples of 130 -> press after the 3rd, then release and ready=0 at MAX_TOUCH, then recalibration to baseline=130; a reset mid-sequence -> all outputs 0 with no release pulse.
